mem_except_ctrl: RTL and testbench

- MEM-stage exception arbiter that sits directly upstream of cp0_reg.
- Collects per-instruction exception flags, the interrupt condition and ERET.
- Produces the excepttype / current_inst_addr / is_in_delayslot / bad_addr bundle that cp0_reg consumes, plus a registered pipeline flush and redirect PC.
- Holds a detected exception across stall so that cp0_reg, which ignores updates while stalled, still records it.

---
 rtl/mem_except_ctrl_pkg.sv | 38 +++
 rtl/mem_except_ctrl_prio_enc.sv | 52 +++++
 rtl/mem_except_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_except_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_except_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception arbiter.
// Codes match the cp0_reg excepttype encoding.
package mem_except_ctrl_pkg;

    localparam int          DATA_W     = 32;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h00;
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_TR   = 32'h0d;
    localparam logic [31:0] EXC_ERET = 32'h0e;

    localparam int FLG_ADEL_FETCH = 0;
    localparam int FLG_SYSCALL    = 1;
    localparam int FLG_BRK        = 2;
    localparam int FLG_RI         = 3;
    localparam int FLG_OV         = 4;
    localparam int FLG_ADEL_DATA  = 5;
    localparam int FLG_ADES       = 6;
    localparam int FLG_ERET       = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_FLUSH
    } state_e;

endpackage

// File: rtl/mem_except_ctrl_prio_enc.sv
// Fixed-priority exception encoder: flags to cp0 excepttype
// code plus the faulting address for address-error cases.
module exc_prio_enc
    import mem_except_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         valid_i,
    input  logic         int_req_i,
    input  logic [7:0]   flags_i,
    input  logic         trap_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] mem_addr_i,
    output logic [W-1:0] code_o,
    output logic [W-1:0] bad_addr_o
);

    logic [7:0] f;
    logic       t;

    always_comb begin
        f          = valid_i ? flags_i : 8'h00;
        t          = valid_i & trap_i;
        code_o     = W'(EXC_NONE);
        bad_addr_o = '0;
        if (int_req_i) begin
            code_o = W'(EXC_INT);
        end else if (f[FLG_ADEL_FETCH]) begin
            code_o     = W'(EXC_ADEL);
            bad_addr_o = pc_i;
        end else if (f[FLG_RI]) begin
            code_o = W'(EXC_RI);
        end else if (f[FLG_OV]) begin
            code_o = W'(EXC_OV);
        end else if (t) begin
            code_o = W'(EXC_TR);
        end else if (f[FLG_SYSCALL]) begin
            code_o = W'(EXC_SYS);
        end else if (f[FLG_BRK]) begin
            code_o = W'(EXC_BP);
        end else if (f[FLG_ADEL_DATA]) begin
            code_o     = W'(EXC_ADEL);
            bad_addr_o = mem_addr_i;
        end else if (f[FLG_ADES]) begin
            code_o     = W'(EXC_ADES);
            bad_addr_o = mem_addr_i;
        end else if (f[FLG_ERET]) begin
            code_o = W'(EXC_ERET);
        end
    end

endmodule

// File: rtl/mem_except_ctrl.sv
// MEM-stage exception arbiter feeding cp0_reg; holds an exception
// across stall and issues a registered one-cycle flush/redirect.
module mem_except_ctrl
    import mem_except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VECTOR,
    parameter int          W       = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         inst_valid_i,
    input  logic [W-1:0] pc_i,
    input  logic         in_delayslot_i,
    input  logic [7:0]   exc_flags_i,
    input  logic         trap_i,
    input  logic [W-1:0] mem_addr_i,
    input  logic [W-1:0] cp0_status_i,
    input  logic [W-1:0] cp0_cause_i,
    input  logic [W-1:0] cp0_epc_i,
    input  logic         wb_cp0_we_i,
    input  logic [4:0]   wb_cp0_waddr_i,
    input  logic [W-1:0] wb_cp0_wdata_i,
    output logic [W-1:0] excepttype_o,
    output logic [W-1:0] exc_pc_o,
    output logic         exc_delayslot_o,
    output logic [W-1:0] bad_addr_o,
    output logic         flush_o,
    output logic [W-1:0] new_pc_o
);

    logic [W-1:0] eff_status, eff_epc;
    logic [7:0]   eff_ip;
    logic         int_req;
    logic [W-1:0] det_code, det_bad, det_npc;

    state_e       state_q, state_d;
    logic [W-1:0] hcode_q, hcode_d;
    logic [W-1:0] hpc_q, hpc_d;
    logic         hds_q, hds_d;
    logic [W-1:0] hbad_q, hbad_d;
    logic [W-1:0] hnpc_q, hnpc_d;
    logic         flush_q, flush_d;
    logic [W-1:0] npc_q, npc_d;

    // Only IP[1:0] of Cause is software-writable.
    always_comb begin
        eff_status = cp0_status_i;
        eff_epc    = cp0_epc_i;
        eff_ip     = cp0_cause_i[15:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS)
            eff_status = wb_cp0_wdata_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC)
            eff_epc = wb_cp0_wdata_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)
            eff_ip[1:0] = wb_cp0_wdata_i[9:8];
    end

    assign int_req = inst_valid_i & eff_status[0] & ~eff_status[1]
                   & |(eff_ip & eff_status[15:8]);

    exc_prio_enc #(.W(W)) u_enc (
        .valid_i    (inst_valid_i),
        .int_req_i  (int_req),
        .flags_i    (exc_flags_i),
        .trap_i     (trap_i),
        .pc_i       (pc_i),
        .mem_addr_i (mem_addr_i),
        .code_o     (det_code),
        .bad_addr_o (det_bad)
    );

    assign det_npc = (det_code == W'(EXC_ERET)) ? eff_epc : W'(EXC_VEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hcode_q <= '0;
            hpc_q   <= '0;
            hds_q   <= 1'b0;
            hbad_q  <= '0;
            hnpc_q  <= '0;
            flush_q <= 1'b0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            hcode_q <= hcode_d;
            hpc_q   <= hpc_d;
            hds_q   <= hds_d;
            hbad_q  <= hbad_d;
            hnpc_q  <= hnpc_d;
            flush_q <= flush_d;
            npc_q   <= npc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        hcode_d         = hcode_q;
        hpc_d           = hpc_q;
        hds_d           = hds_q;
        hbad_d          = hbad_q;
        hnpc_d          = hnpc_q;
        flush_d         = 1'b0;
        npc_d           = '0;
        excepttype_o    = '0;
        exc_pc_o        = '0;
        exc_delayslot_o = 1'b0;
        bad_addr_o      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (det_code != '0) begin
                    if (!stall) begin
                        excepttype_o    = det_code;
                        exc_pc_o        = pc_i;
                        exc_delayslot_o = in_delayslot_i;
                        bad_addr_o      = det_bad;
                        flush_d         = 1'b1;
                        npc_d           = det_npc;
                        state_d         = S_FLUSH;
                    end else begin
                        hcode_d = det_code;
                        hpc_d   = pc_i;
                        hds_d   = in_delayslot_i;
                        hbad_d  = det_bad;
                        hnpc_d  = det_npc;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                exc_pc_o        = hpc_q;
                exc_delayslot_o = hds_q;
                bad_addr_o      = hbad_q;
                if (!stall) begin
                    excepttype_o = hcode_q;
                    flush_d      = 1'b1;
                    npc_d        = hnpc_q;
                    state_d      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Keep cp0_reg from seeing a stale bundle while reset is held.
        if (rst) begin
            excepttype_o    = '0;
            exc_pc_o        = '0;
            exc_delayslot_o = 1'b0;
            bad_addr_o      = '0;
        end
    end

    assign flush_o  = flush_q;
    assign new_pc_o = npc_q;

endmodule

// File: tb/tb_mem_except_ctrl.sv
// Scoreboard bench for mem_except_ctrl: stimulus queues expected
// exception/flush events, a negedge monitor pops and compares.
module tb_mem_except_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, inst_valid_i, in_delayslot_i, trap_i;
    logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic [7:0]  exc_flags_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
    logic        exc_delayslot_o, flush_o;

    typedef struct {
        bit          is_flush;
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    always #5 clk = ~clk;

    mem_except_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .inst_valid_i    (inst_valid_i),
        .pc_i            (pc_i),
        .in_delayslot_i  (in_delayslot_i),
        .exc_flags_i     (exc_flags_i),
        .trap_i          (trap_i),
        .mem_addr_i      (mem_addr_i),
        .cp0_status_i    (cp0_status_i),
        .cp0_cause_i     (cp0_cause_i),
        .cp0_epc_i       (cp0_epc_i),
        .wb_cp0_we_i     (wb_cp0_we_i),
        .wb_cp0_waddr_i  (wb_cp0_waddr_i),
        .wb_cp0_wdata_i  (wb_cp0_wdata_i),
        .excepttype_o    (excepttype_o),
        .exc_pc_o        (exc_pc_o),
        .exc_delayslot_o (exc_delayslot_o),
        .bad_addr_o      (bad_addr_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exc(input logic [31:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] bad);
        exp_t e;
        e.is_flush = 1'b0;
        e.code = code;
        e.pc = pc;
        e.ds = ds;
        e.bad = bad;
        e.npc = '0;
        sb.push_back(e);
    endtask

    task automatic push_fl(input logic [31:0] npc);
        exp_t e;
        e.is_flush = 1'b1;
        e.code = '0;
        e.pc = '0;
        e.ds = 1'b0;
        e.bad = '0;
        e.npc = npc;
        sb.push_back(e);
    endtask

    // Monitor: every visible exception or flush must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (excepttype_o != 32'h0) begin
                n_cmp++;
                if (sb.size() == 0 || sb[0].is_flush) begin
                    n_bad++;
                    $display("FAIL exc_event: unexpected excepttype %h pc %h",
                             excepttype_o, exc_pc_o);
                end else begin
                    e = sb.pop_front();
                    if (excepttype_o !== e.code || exc_pc_o !== e.pc ||
                        exc_delayslot_o !== e.ds || bad_addr_o !== e.bad) begin
                        n_bad++;
                        $display("FAIL exc_bundle: got %h/%h/%b/%h expected %h/%h/%b/%h",
                                 excepttype_o, exc_pc_o, exc_delayslot_o,
                                 bad_addr_o, e.code, e.pc, e.ds, e.bad);
                    end
                end
            end
            if (flush_o) begin
                n_cmp++;
                if (sb.size() == 0 || !sb[0].is_flush) begin
                    n_bad++;
                    $display("FAIL flush_event: unexpected flush new_pc %h",
                             new_pc_o);
                end else begin
                    e = sb.pop_front();
                    if (new_pc_o !== e.npc) begin
                        n_bad++;
                        $display("FAIL flush_pc: got %h expected %h",
                                 new_pc_o, e.npc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0;
        inst_valid_i = 0;
        in_delayslot_i = 0;
        pc_i = '0;
        exc_flags_i = '0;
        trap_i = 0;
        mem_addr_i = '0;
        cp0_status_i = '0;
        cp0_cause_i = '0;
        cp0_epc_i = '0;
        wb_cp0_we_i = 0;
        wb_cp0_waddr_i = '0;
        wb_cp0_wdata_i = '0;
    endtask

    task automatic inst(input logic [31:0] pc, input logic [7:0] fl);
        inst_valid_i = 1;
        pc_i = pc;
        exc_flags_i = fl;
    endtask

    task automatic quiet_chk(input string nm);
        @(negedge clk);
        chk({nm, "_exc"}, excepttype_o, 32'h0);
        chk({nm, "_flush"}, {31'h0, flush_o}, 32'h0);
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_exc", excepttype_o, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_npc", new_pc_o, 32'h0);
        tick();
        rst = 0;

        // syscall, no stall
        inst(32'h8000_1000, 8'h02);
        push_exc(32'h8, 32'h8000_1000, 0, 0);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // adel_data held across a 3-cycle stall; a younger ri is ignored
        inst(32'h8000_2000, 8'h20);
        in_delayslot_i = 1;
        mem_addr_i = 32'h8000_0003;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_exc", excepttype_o, 32'h0);
            tick();
            if (i == 0) begin
                inst(32'h8000_9999, 8'h08);
                in_delayslot_i = 0;
                mem_addr_i = '0;
            end
        end
        stall = 0;
        push_exc(32'h4, 32'h8000_2000, 1, 32'h8000_0003);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // eret with EPC forwarded from in-flight mtc0
        inst(32'h8000_3000, 8'h80);
        cp0_epc_i = 32'h100;
        wb_cp0_we_i = 1;
        wb_cp0_waddr_i = 5'd14;
        wb_cp0_wdata_i = 32'h200;
        push_exc(32'he, 32'h8000_3000, 0, 0);
        push_fl(32'h200);
        tick();
        clr();
        tick();

        // interrupt beats ov
        inst(32'h8000_4000, 8'h10);
        cp0_status_i = 32'h0000_0401;
        cp0_cause_i = 32'h0000_0400;
        push_exc(32'h1, 32'h8000_4000, 0, 0);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // software interrupt via forwarded Cause IP0
        inst(32'h8000_4100, 8'h00);
        cp0_status_i = 32'h0000_0101;
        wb_cp0_we_i = 1;
        wb_cp0_waddr_i = 5'd13;
        wb_cp0_wdata_i = 32'h0000_0100;
        push_exc(32'h1, 32'h8000_4100, 0, 0);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // Cause bit 10 is not software-writable: no interrupt
        inst(32'h8000_4200, 8'h00);
        cp0_status_i = 32'h0000_0401;
        wb_cp0_we_i = 1;
        wb_cp0_waddr_i = 5'd13;
        wb_cp0_wdata_i = 32'h0000_0400;
        quiet_chk("ip_mask");
        tick();
        clr();

        // adel_fetch outranks ri and trap
        inst(32'h8000_5000, 8'h09);
        trap_i = 1;
        push_exc(32'h4, 32'h8000_5000, 0, 32'h8000_5000);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // trap outranks syscall and ades
        inst(32'h8000_5100, 8'h42);
        trap_i = 1;
        mem_addr_i = 32'h1234_5678;
        push_exc(32'hd, 32'h8000_5100, 0, 0);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // ades
        inst(32'h8000_5200, 8'h40);
        mem_addr_i = 32'h8000_0006;
        push_exc(32'h5, 32'h8000_5200, 0, 32'h8000_0006);
        push_fl(VEC);
        tick();
        clr();
        tick();

        // EXL masks interrupt
        inst(32'h8000_6000, 8'h00);
        cp0_status_i = 32'h0000_0403;
        cp0_cause_i = 32'h0000_0400;
        quiet_chk("exl");
        tick();
        clr();
        quiet_chk("exl_next");
        tick();

        // bubble masks interrupt and flags
        cp0_status_i = 32'h0000_0401;
        cp0_cause_i = 32'h0000_0400;
        exc_flags_i = 8'h02;
        pc_i = 32'h8000_6100;
        quiet_chk("bubble");
        tick();
        clr();
        quiet_chk("bubble_next");
        tick();

        // reset while in HOLD
        inst(32'h8000_7000, 8'h02);
        stall = 1;
        tick();
        rst = 1;
        @(negedge clk);
        chk("hold_rst_exc", excepttype_o, 32'h0);
        chk("hold_rst_pc", exc_pc_o, 32'h0);
        tick();
        rst = 0;
        clr();
        quiet_chk("post_rst");
        chk("post_rst_npc", new_pc_o, 32'h0);
        tick();
        quiet_chk("post_rst2");
        tick();

        // ri, then syscall in the FLUSH cycle is dropped
        inst(32'h8000_8000, 8'h08);
        push_exc(32'ha, 32'h8000_8000, 0, 0);
        push_fl(VEC);
        tick();
        inst(32'h8000_8004, 8'h02);
        @(negedge clk);
        chk("flush_ignore", excepttype_o, 32'h0);
        tick();
        clr();
        tick();

        // brk afterwards proves return to IDLE
        inst(32'h8000_9000, 8'h04);
        push_exc(32'h9, 32'h8000_9000, 0, 0);
        push_fl(VEC);
        tick();
        clr();
        repeat (3) tick();

        chk("sb_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
